// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational instruction memory
// into the IF/ID register under valid/ready, with redirect, boot hold and misaligned-PC fault.
module if_fetch_ctrl #(
    parameter int unsigned                   PC_WIDTH_LENGTH   = 32,
    parameter int unsigned                   INST_WIDTH_LENGTH = 32,
    parameter logic [PC_WIDTH_LENGTH-1:0]    RESET_PC          = '0,
    parameter int unsigned                   BOOT_CYCLES       = 4,
    parameter int unsigned                   CNT_W             = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [PC_WIDTH_LENGTH-1:0]   imem_addr,
    input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [INST_WIDTH_LENGTH-1:0] id_inst,
    output logic [PC_WIDTH_LENGTH-1:0]   id_pc,
    output logic                         fault,
    output logic [PC_WIDTH_LENGTH-1:0]   fault_pc,
    output logic [CNT_W-1:0]             inst_count
);

    localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BootW-1:0] BootLast = BootW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFault
    } state_e;

    state_e                         r_state, w_state_d;
    logic [BootW-1:0]               r_boot_cnt, w_boot_cnt_d;
    logic [PC_WIDTH_LENGTH-1:0]     r_pc, w_pc_d;
    logic                           r_id_valid, w_id_valid_d;
    logic [INST_WIDTH_LENGTH-1:0]   r_id_inst, w_id_inst_d;
    logic [PC_WIDTH_LENGTH-1:0]     r_id_pc, w_id_pc_d;
    logic [PC_WIDTH_LENGTH-1:0]     r_fault_pc, w_fault_pc_d;
    logic [CNT_W-1:0]               r_inst_count, w_inst_count_d;

    logic w_slot_free;
    logic w_aligned;
    logic w_in_run;
    logic w_redirect_taken;
    logic w_fire;
    logic w_misalign;
    logic w_deliver;

    assign w_slot_free      = !r_id_valid || id_ready;
    assign w_aligned        = (r_pc[1:0] == 2'b00);
    assign w_in_run         = (r_state == StRun);
    // Redirects during boot only move the PC; they never leave BOOT early.
    assign w_redirect_taken = redirect_valid && (r_state != StBoot);
    assign w_fire           = w_in_run && w_slot_free && !redirect_valid && w_aligned;
    assign w_misalign       = w_in_run && w_slot_free && !redirect_valid && !w_aligned;
    assign w_deliver        = r_id_valid && id_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StBoot;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StBoot: begin
                if (r_boot_cnt == BootLast) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    w_state_d = StRun;
                end else if (w_misalign) begin
                    w_state_d = StFault;
                end
            end
            StFault: begin
                if (redirect_valid) begin
                    w_state_d = StRun;
                end
            end
            default: w_state_d = StBoot;
        endcase
    end

    // Outputs
    always_comb begin
        imem_addr  = r_pc;
        id_valid   = r_id_valid;
        id_inst    = r_id_inst;
        id_pc      = r_id_pc;
        fault      = (r_state == StFault);
        fault_pc   = r_fault_pc;
        inst_count = r_inst_count;
    end

    // Datapath next values
    always_comb begin
        w_boot_cnt_d   = r_boot_cnt;
        w_pc_d         = r_pc;
        w_id_valid_d   = r_id_valid;
        w_id_inst_d    = r_id_inst;
        w_id_pc_d      = r_id_pc;
        w_fault_pc_d   = r_fault_pc;
        w_inst_count_d = r_inst_count;

        if (r_state == StBoot) begin
            w_boot_cnt_d = r_boot_cnt + BootW'(1);
            if (redirect_valid) begin
                w_pc_d = redirect_pc;
            end
        end

        if (w_redirect_taken) begin
            // Flush wins even when decode accepts the word this cycle.
            w_pc_d       = redirect_pc;
            w_id_valid_d = 1'b0;
        end else if (w_fire) begin
            w_id_valid_d = 1'b1;
            w_id_inst_d  = imem_inst;
            w_id_pc_d    = r_pc;
            w_pc_d       = r_pc + PC_WIDTH_LENGTH'(4);
        end else if (w_misalign) begin
            w_id_valid_d = 1'b0;
            w_fault_pc_d = r_pc;
        end else if (r_state == StFault) begin
            w_id_valid_d = 1'b0;
        end

        if (w_deliver) begin
            w_inst_count_d = r_inst_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_boot_cnt   <= '0;
            r_pc         <= RESET_PC;
            r_id_valid   <= 1'b0;
            r_id_inst    <= '0;
            r_id_pc      <= '0;
            r_fault_pc   <= '0;
            r_inst_count <= '0;
        end else begin
            r_boot_cnt   <= w_boot_cnt_d;
            r_pc         <= w_pc_d;
            r_id_valid   <= w_id_valid_d;
            r_id_inst    <= w_id_inst_d;
            r_id_pc      <= w_id_pc_d;
            r_fault_pc   <= w_fault_pc_d;
            r_inst_count <= w_inst_count_d;
        end
    end

endmodule
